// File: rtl/zxuno_video_turbo_ctrl.sv
// ZX-Uno video/turbo config register bank with keyboard hotkeys,
// PRISM alias port write and change strobes for scandoubler/clock mux.
module zxuno_video_turbo_ctrl #(
    parameter logic [7:0]  BASE_ADDR    = 8'h0B,
    parameter int          NREGS        = 2,
    parameter logic [7:0]  RESET_REG0   = 8'h00,
    parameter logic [15:0] ALIAS_PORT   = 16'h8E3B,
    parameter logic [2:0]  VGA_FREQ     = 3'b101,
    parameter bit          HOTKEY_3STEP = 1'b1,
    parameter logic [21:0] HOLDOFF      = 22'd2800000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        a,
    input  logic               iorq_n,
    input  logic               wr_n,
    input  logic [7:0]         zxuno_addr,
    input  logic               zxuno_regrd,
    input  logic               zxuno_regwr,
    input  logic [7:0]         din,
    input  logic               kbd_video_key,
    input  logic               kbd_turbo_key,
    output logic [7:0]         dout,
    output logic               oe_n,
    output logic               vga_enable,
    output logic               scanlines_enable,
    output logic [2:0]         freq_option,
    output logic [1:0]         turbo_enable,
    output logic [8*NREGS-1:0] regs_flat,
    output logic               video_changed,
    output logic               turbo_changed
);

    localparam logic [7:0] NR8 = 8'(NREGS);

    logic [7:0]  r_regs [NREGS];
    logic [7:0]  r_prev0;
    logic [21:0] r_hold;
    logic [1:0]  r_ok;
    logic        r_v_s1, r_v_s2, r_v_d, r_v_arm, r_vpend;
    logic        r_t_s1, r_t_s2, r_t_d, r_t_arm, r_tpend;
    logic        r_alias_d;

    logic [7:0]  w_off;
    logic        w_in_range;
    logic        w_zx_wr, w_zx_wr0;
    logic        w_alias_q, w_alias_wr;
    logic        w_block, w_hold_z;
    logic        w_v_edge, w_t_edge;
    logic        w_v_req, w_t_req, w_v_go, w_t_go;
    logic [7:0]  w_reg0_nx;
    logic [7:0]  w_rd;

    assign w_off      = zxuno_addr - BASE_ADDR;
    assign w_in_range = (zxuno_addr >= BASE_ADDR) && (w_off < NR8);
    assign w_zx_wr    = zxuno_regwr & w_in_range;
    assign w_zx_wr0   = w_zx_wr & (w_off == 8'd0);
    assign w_alias_q  = ~iorq_n & ~wr_n & (a == ALIAS_PORT);
    assign w_alias_wr = w_alias_q & ~r_alias_d;
    assign w_block    = w_zx_wr0 | w_alias_wr;
    assign w_hold_z   = (r_hold == 22'd0);

    // arm flags ignore keys already held when reset is released
    assign w_v_edge = r_v_s2 & ~r_v_d & r_v_arm;
    assign w_t_edge = r_t_s2 & ~r_t_d & r_t_arm;
    assign w_v_req  = r_vpend | (w_v_edge & w_hold_z);
    assign w_t_req  = r_tpend | (w_t_edge & w_hold_z);
    assign w_v_go   = w_v_req & ~w_block;
    assign w_t_go   = w_t_req & ~w_block;

    always_comb begin
        w_reg0_nx = r_regs[0];
        if (w_zx_wr0) begin
            w_reg0_nx = din;
        end else if (w_alias_wr) begin
            w_reg0_nx[7:6] = din[1:0];
        end else begin
            if (w_v_go) begin
                case (r_regs[0][1:0])
                    2'b01: begin
                        if (HOTKEY_3STEP) w_reg0_nx[1:0] = 2'b11;
                        else              w_reg0_nx[4:0] = 5'd0;
                    end
                    2'b11:   w_reg0_nx[4:0] = 5'd0;
                    default: begin
                        w_reg0_nx[1:0] = 2'b01;
                        w_reg0_nx[4:2] = VGA_FREQ;
                    end
                endcase
            end
            if (w_t_go) w_reg0_nx[7:6] = r_regs[0][7:6] + 2'd1;
        end
    end

    always_comb begin
        w_rd = 8'h00;
        for (int i = 0; i < NREGS; i++)
            if (w_in_range && (w_off == 8'(i))) w_rd = r_regs[i];
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NREGS; i++)
            regs_flat[8*i +: 8] = r_regs[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ok      <= 2'b00;
            r_v_s1    <= 1'b0;
            r_v_s2    <= 1'b0;
            r_v_d     <= 1'b0;
            r_v_arm   <= 1'b0;
            r_t_s1    <= 1'b0;
            r_t_s2    <= 1'b0;
            r_t_d     <= 1'b0;
            r_t_arm   <= 1'b0;
            r_alias_d <= 1'b0;
        end else begin
            r_ok      <= {r_ok[0], 1'b1};
            r_v_s1    <= kbd_video_key;
            r_v_s2    <= r_v_s1;
            r_v_d     <= r_v_s2;
            r_v_arm   <= r_v_arm | (r_ok[1] & ~r_v_s2);
            r_t_s1    <= kbd_turbo_key;
            r_t_s2    <= r_t_s1;
            r_t_d     <= r_t_s2;
            r_t_arm   <= r_t_arm | (r_ok[1] & ~r_t_s2);
            r_alias_d <= w_alias_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vpend <= 1'b0;
            r_tpend <= 1'b0;
            r_hold  <= 22'd0;
        end else begin
            r_vpend <= w_block & w_v_req;
            r_tpend <= w_block & w_t_req;
            if (w_v_go | w_t_go) r_hold <= HOLDOFF;
            else if (!w_hold_z)  r_hold <= r_hold - 22'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= (i == 0) ? RESET_REG0 : 8'h00;
        end else begin
            r_regs[0] <= w_reg0_nx;
            for (int i = 1; i < NREGS; i++)
                if (w_zx_wr && (w_off == 8'(i))) r_regs[i] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout          <= 8'h00;
            r_prev0       <= RESET_REG0;
            video_changed <= 1'b0;
            turbo_changed <= 1'b0;
        end else begin
            dout          <= w_rd;
            r_prev0       <= r_regs[0];
            video_changed <= (r_regs[0][4:0] != r_prev0[4:0]);
            turbo_changed <= (r_regs[0][7:6] != r_prev0[7:6]);
        end
    end

    assign oe_n             = ~(zxuno_regrd & w_in_range);
    assign vga_enable       = r_regs[0][0];
    assign scanlines_enable = r_regs[0][1];
    assign freq_option      = r_regs[0][4:2];
    assign turbo_enable     = r_regs[0][7:6];

endmodule
